stoplight_ctrl: RTL and testbench

Sequencing controller for the stoplight design. It owns a phase timer, which is a clear/enable counter with a terminal-count flag. It steps a two-way intersection (north–south, east–west) through green, yellow and all-red phases, and inserts a pedestrian walk phase on request. Light outputs drive the top-level light pins directly.

---
 rtl/stoplight_pkg.sv | 20 ++
 rtl/stoplight_ctrl_phase_timer.sv | 29 ++
 rtl/stoplight_ctrl.sv | 117 +++++++++++
 tb/tb_stoplight_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stoplight_pkg.sv
// Shared types for the stoplight controller: lamp encoding and FSM states.
package stoplight_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

  typedef enum logic [2:0] {
    AR_NS,
    NS_G,
    NS_Y,
    AR_EW,
    EW_G,
    EW_Y,
    WALK
  } state_t;

endpackage

// File: rtl/stoplight_ctrl_phase_timer.sv
// Phase timer: clear/enable up-counter that flags when it has reached the
// dwell limit of the current phase.
module phase_timer #(
  parameter int TIMER_W = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               clear,
  input  logic               enable,
  input  logic [TIMER_W-1:0] limit,
  output logic               at_limit
);

  logic [TIMER_W-1:0] r_count;

  // Count enabled cycles within a phase; a clear restarts the phase at zero.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  assign at_limit = (r_count == limit);

endmodule

// File: rtl/stoplight_ctrl.sv
// Two-way intersection sequencer with an optional pedestrian walk phase
// inserted after an all-red phase whenever a request is pending.
module stoplight_ctrl
  import stoplight_pkg::*;
#(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 2,
  parameter int WALK_CYCLES   = 6,
  parameter int TIMER_W       = 4
) (
  input  logic   clk,
  input  logic   nrst,
  input  logic   enable,
  input  logic   ped_req,
  output light_t ns_light,
  output light_t ew_light,
  output logic   ped_walk,
  output logic   ped_ack
);

  localparam logic [TIMER_W-1:0] LIM_GREEN  = TIMER_W'(GREEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LIM_YELLOW = TIMER_W'(YELLOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LIM_ALLRED = TIMER_W'(ALLRED_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LIM_WALK   = TIMER_W'(WALK_CYCLES - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic               r_pedPending;
  logic               r_walkToEw;
  logic               r_pedAck;
  logic [TIMER_W-1:0] w_limit;
  logic               w_atLimit;
  logic               w_advance;
  logic               w_enterWalk;

  // A phase ends only on an enabled cycle whose timer has hit the dwell limit.
  assign w_advance   = enable & w_atLimit;
  assign w_enterWalk = w_advance & (w_nextState == WALK);

  phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .nrst     (nrst),
    .clear    (w_advance),
    .enable   (enable),
    .limit    (w_limit),
    .at_limit (w_atLimit)
  );

  // Pick the dwell limit that belongs to the phase currently being timed.
  always_comb begin
    w_limit = LIM_ALLRED;
    case (r_state)
      NS_G, EW_G: w_limit = LIM_GREEN;
      NS_Y, EW_Y: w_limit = LIM_YELLOW;
      WALK:       w_limit = LIM_WALK;
      default:    w_limit = LIM_ALLRED;
    endcase
  end

  // State register plus the pending request, walk destination and ack pulse;
  // entering WALK consumes the request even if ped_req is still high.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= AR_NS;
      r_pedPending <= 1'b0;
      r_walkToEw   <= 1'b0;
      r_pedAck     <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_pedAck <= w_enterWalk;
      if (w_enterWalk) begin
        r_pedPending <= 1'b0;
        r_walkToEw   <= (r_state == AR_EW);
      end else if (ped_req && (r_state != WALK)) begin
        r_pedPending <= 1'b1;
      end
    end
  end

  // Base cycle with the walk phase spliced in after an all-red when pending.
  always_comb begin
    w_nextState = r_state;
    if (w_advance) begin
      case (r_state)
        AR_NS:   w_nextState = r_pedPending ? WALK : NS_G;
        NS_G:    w_nextState = NS_Y;
        NS_Y:    w_nextState = AR_EW;
        AR_EW:   w_nextState = r_pedPending ? WALK : EW_G;
        EW_G:    w_nextState = EW_Y;
        EW_Y:    w_nextState = AR_NS;
        WALK:    w_nextState = r_walkToEw ? EW_G : NS_G;
        default: w_nextState = AR_NS;
      endcase
    end
  end

  // Moore lamp decode: any lamp not driven by the current state stays RED.
  always_comb begin
    ns_light = RED;
    ew_light = RED;
    ped_walk = 1'b0;
    case (r_state)
      NS_G:    ns_light = GREEN;
      NS_Y:    ns_light = YELLOW;
      EW_G:    ew_light = GREEN;
      EW_Y:    ew_light = YELLOW;
      WALK:    ped_walk = 1'b1;
      default: ;
    endcase
  end

  assign ped_ack = r_pedAck;

endmodule

// File: tb/tb_stoplight_ctrl.sv
// Directed bench for stoplight_ctrl: default timing plus a minimum-dwell build.
module tb_stoplight_ctrl;
  import stoplight_pkg::*;

  logic   clk = 1'b0;
  logic   nrst;
  logic   enable;
  logic   ped_req;
  light_t ns_light;
  light_t ew_light;
  logic   ped_walk;
  logic   ped_ack;

  logic   nrstMin;
  logic   enableMin;
  logic   pedReqMin;
  light_t nsMin;
  light_t ewMin;
  logic   walkMin;
  logic   ackMin;

  int errors = 0;
  int checks = 0;
  bit monitorOn = 1'b0;

  light_t nsMinExp [14] = '{GREEN, YELLOW, RED, RED, RED, RED, GREEN,
                            YELLOW, RED, RED, RED, RED, RED, GREEN};
  light_t ewMinExp [14] = '{RED, RED, RED, GREEN, YELLOW, RED, RED,
                            RED, RED, RED, GREEN, YELLOW, RED, RED};

  always #5 clk = ~clk;

  stoplight_ctrl dut (
    .clk      (clk),
    .nrst     (nrst),
    .enable   (enable),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .ped_walk (ped_walk),
    .ped_ack  (ped_ack)
  );

  stoplight_ctrl #(
    .GREEN_CYCLES  (1),
    .YELLOW_CYCLES (1),
    .ALLRED_CYCLES (1),
    .WALK_CYCLES   (1),
    .TIMER_W       (1)
  ) dutMin (
    .clk      (clk),
    .nrst     (nrstMin),
    .enable   (enableMin),
    .ped_req  (pedReqMin),
    .ns_light (nsMin),
    .ew_light (ewMin),
    .ped_walk (walkMin),
    .ped_ack  (ackMin)
  );

  // Safety invariant on both instances: never two non-RED lamps, and walk only with all RED.
  always @(negedge clk) begin
    if (monitorOn) begin
      checks += 2;
      if ((ns_light !== RED && ew_light !== RED) || (ped_walk === 1'b1 && (ns_light !== RED || ew_light !== RED))) begin
        errors++;
        $display("[TB] FAIL safety_default ns=%0d ew=%0d walk=%b required exclusive lamps", ns_light, ew_light, ped_walk);
      end
      if ((nsMin !== RED && ewMin !== RED) || (walkMin === 1'b1 && (nsMin !== RED || ewMin !== RED))) begin
        errors++;
        $display("[TB] FAIL safety_min ns=%0d ew=%0d walk=%b required exclusive lamps", nsMin, ewMin, walkMin);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input int n);
    nrst = 1'b0;
    repeat (n) step();
    nrst = 1'b1;
  endtask

  // Hand-derived schedule, k = edges since reset release. Base period 26:
  // AR_NS 0-1, NS_G 2-9, NS_Y 10-12, AR_EW 13-14, EW_G 15-22, EW_Y 23-25.
  // With a walk after the first AR_EW: WALK 15-20, then the base schedule shifted by 6.
  function automatic logic [5:0] expSchedule(input int k, input bit withWalk);
    light_t nsE;
    light_t ewE;
    logic   wE;
    logic   aE;
    int     m;
    nsE = RED;
    ewE = RED;
    wE  = 1'b0;
    aE  = 1'b0;
    m   = k;
    if (withWalk && k >= 15 && k < 21) begin
      wE = 1'b1;
      aE = (k == 15);
      m  = -1;
    end else if (withWalk && k >= 21) begin
      m = k - 6;
    end
    if (m >= 0) begin
      m = m % 26;
      if (m >= 2 && m < 10)       nsE = GREEN;
      else if (m >= 10 && m < 13) nsE = YELLOW;
      else if (m >= 15 && m < 23) ewE = GREEN;
      else if (m >= 23)           ewE = YELLOW;
    end
    return {nsE, ewE, wE, aE};
  endfunction

  task automatic test_reset();
    logic [5:0] obs;
    enable  = 1'b1;
    ped_req = 1'b0;
    applyReset(2);
    obs = {ns_light, ew_light, ped_walk, ped_ack};
    checks++;
    if (obs !== {RED, RED, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_initial actual=%h required=%h", obs, {RED, RED, 1'b0, 1'b0});
    end
    repeat (18) step();
    checks++;
    if (ew_light !== GREEN) begin
      errors++;
      $display("[TB] FAIL reset_pre_ewg ew actual=%0d required=%0d", ew_light, GREEN);
    end
    nrst = 1'b0;
    step();
    step();
    obs = {ns_light, ew_light, ped_walk, ped_ack};
    checks++;
    if (obs !== {RED, RED, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_mid_ewg actual=%h required=%h", obs, {RED, RED, 1'b0, 1'b0});
    end
    nrst = 1'b1;
    step();
    checks++;
    if (ns_light !== RED) begin
      errors++;
      $display("[TB] FAIL reset_release_k1 ns actual=%0d required=%0d", ns_light, RED);
    end
    step();
    checks++;
    if (ns_light !== GREEN) begin
      errors++;
      $display("[TB] FAIL reset_release_k2 ns actual=%0d required=%0d", ns_light, GREEN);
    end
  endtask

  task automatic test_free_run();
    logic [5:0] obs;
    logic [5:0] expv;
    applyReset(2);
    for (int k = 1; k <= 60; k++) begin
      step();
      obs  = {ns_light, ew_light, ped_walk, ped_ack};
      expv = expSchedule(k, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL free_run k=%0d actual=%h required=%h", k, obs, expv);
      end
    end
  endtask

  task automatic test_ped_ns_green();
    logic [5:0] obs;
    logic [5:0] expv;
    applyReset(2);
    for (int k = 1; k <= 40; k++) begin
      ped_req = (k == 6);
      step();
      obs  = {ns_light, ew_light, ped_walk, ped_ack};
      expv = expSchedule(k, 1'b1);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL ped_ns_green k=%0d actual=%h required=%h", k, obs, expv);
      end
    end
    ped_req = 1'b0;
  endtask

  task automatic test_ped_last_ar();
    logic [5:0] obs;
    logic [5:0] expv;
    applyReset(2);
    for (int k = 1; k <= 40; k++) begin
      ped_req = (k >= 2 && k <= 21);
      step();
      obs  = {ns_light, ew_light, ped_walk, ped_ack};
      expv = expSchedule(k, 1'b1);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL ped_last_ar k=%0d actual=%h required=%h", k, obs, expv);
      end
    end
    ped_req = 1'b0;
  endtask

  task automatic test_enable_hold();
    logic [5:0] obs;
    logic [5:0] expv;
    applyReset(2);
    for (int k = 1; k <= 11; k++) begin
      step();
      obs  = {ns_light, ew_light, ped_walk, ped_ack};
      expv = expSchedule(k, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL hold_lead k=%0d actual=%h required=%h", k, obs, expv);
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ped_req = (i == 2);
      step();
      obs = {ns_light, ew_light, ped_walk, ped_ack};
      checks++;
      if (obs !== {YELLOW, RED, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL hold_frozen i=%0d actual=%h required=%h", i, obs, {YELLOW, RED, 1'b0, 1'b0});
      end
    end
    ped_req = 1'b0;
    enable  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      obs = {ns_light, ew_light, ped_walk, ped_ack};
      case (i)
        0:       expv = {YELLOW, RED, 1'b0, 1'b0};
        1, 2:    expv = {RED, RED, 1'b0, 1'b0};
        3:       expv = {RED, RED, 1'b1, 1'b1};
        default: expv = {RED, RED, 1'b1, 1'b0};
      endcase
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL hold_resume i=%0d actual=%h required=%h", i, obs, expv);
      end
    end
  endtask

  task automatic test_min_dwell();
    logic [5:0] obs;
    logic [5:0] expv;
    nrstMin = 1'b0;
    step();
    step();
    nrstMin = 1'b1;
    obs = {nsMin, ewMin, walkMin, ackMin};
    checks++;
    if (obs !== {RED, RED, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL min_reset actual=%h required=%h", obs, {RED, RED, 1'b0, 1'b0});
    end
    for (int k = 1; k <= 14; k++) begin
      pedReqMin = (k == 7);
      step();
      obs  = {nsMin, ewMin, walkMin, ackMin};
      expv = {nsMinExp[k-1], ewMinExp[k-1], (k == 10), (k == 10)};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL min_dwell k=%0d actual=%h required=%h", k, obs, expv);
      end
    end
    pedReqMin = 1'b0;
  endtask

  initial begin
    nrst      = 1'b0;
    enable    = 1'b1;
    ped_req   = 1'b0;
    nrstMin   = 1'b0;
    enableMin = 1'b1;
    pedReqMin = 1'b0;
    step();
    step();
    monitorOn = 1'b1;
    test_reset();
    test_free_run();
    test_ped_ns_green();
    test_ped_last_ar();
    test_enable_hold();
    test_min_dwell();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
